pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Consumes the PLL `locked` status in the 56 MHz core clock domain (PLL `outclk_0`).
- Synchronises and filters `locked`, then holds the core in reset for a fixed interval before releasing it.
- Generates phase-aligned 7 MHz pixel clock enables (`ce_pix`, `ce_pix_n`) that start exactly at reset release.
- On loss of lock: reasserts core reset at once, stops the enables, counts the event.

Parameters:
- LOCK_FILTER, 1024: consecutive synchronised-high cycles of `locked` required before the hold phase; range 1..2^CNT_W-1.
- RESET_HOLD, 256: cycles `sys_reset` stays high after the filter passes; range 1..2^CNT_W-1.
- CE_DIV, 8: clock-enable divide ratio (56 MHz / 8 = 7 MHz); even, at least 2.
- CNT_W, 16: width of the shared filter/hold counter.

Ports:
- clk, in, 1: core clock (56 MHz).
- rst, in, 1: asynchronous, active-high reset.
- locked, in, 1: PLL lock status; asynchronous to clk.
- sys_reset, out, 1: active-high core reset; registered.
- ready, out, 1: high while in RUN; registered, equals ~sys_reset.
- ce_pix, out, 1: one-cycle enable, every CE_DIV cycles; registered.
- ce_pix_n, out, 1: one-cycle enable, offset by CE_DIV/2 from ce_pix; registered.
- loss_count, out, 8: saturating count of lock losses after the filter has passed.

Behaviour:
- Reset (rst=1, asynchronous):
  - Registers: sync flops 0, state WAIT_LOCK, counter 0, div_cnt 0.
  - Outputs: sys_reset=1, ready=0, ce_pix=0, ce_pix_n=0, loss_count=0.
- Synchroniser: 2-flop chain on `locked`; output is locked_s. Only locked_s is used internally.
- State machine (one transition per clk edge):
  - WAIT_LOCK: if locked_s=1, go to FILTER and clear the counter.
  - FILTER: if locked_s=0, go to WAIT_LOCK; loss_count is not incremented. Otherwise increment the counter. At counter = LOCK_FILTER-1, go to HOLD and clear the counter.
  - HOLD: if locked_s=0, go to WAIT_LOCK and increment loss_count. Otherwise increment the counter. At counter = RESET_HOLD-1, go to RUN and clear div_cnt.
  - RUN: if locked_s=0, go to WAIT_LOCK and increment loss_count. Otherwise div_cnt = (div_cnt+1) mod CE_DIV.
- Output timing:
  - sys_reset/ready update on the same edge as the state register. sys_reset=0 exactly while state=RUN.
  - Release timing: `locked` is stable high from before edge 1. locked_s goes high at edge 2, FILTER is entered at edge 3, and sys_reset falls at edge 3+LOCK_FILTER+RESET_HOLD.
- Clock enables:
  - In RUN, ce_pix=1 when div_cnt=0 and ce_pix_n=1 when div_cnt=CE_DIV/2, both registered with the state.
  - The first ce_pix pulse coincides with the first cycle sys_reset=0.
  - Outside RUN both enables are 0. No partial or stray pulse is allowed on entry to or exit from RUN.
- Loss of lock:
  - `locked` falls before edge 1; locked_s falls at edge 2.
  - sys_reset=1, ready=0 and the enables go to 0 at edge 3 (maximum 3 cycles).
  - Re-acquisition then requires the full filter and hold sequence again.
- Glitches: a locked_s low pulse of any length during FILTER restarts filtering from WAIT_LOCK.
- loss_count: saturates at 255. Cleared only by rst.
- Simultaneous events: locked_s=0 in the same cycle a counter reaches its terminal value means loss wins, next state is WAIT_LOCK.
- rst mid-operation: immediate return to reset values, independent of clk.

Test Plan:
- Params LOCK_FILTER=4, RESET_HOLD=3, CE_DIV=8; rst released, `locked` held high from before edge 1 -> sys_reset=1 through edge 9, sys_reset=0/ready=1 at edge 10, ce_pix=1 at edges 10,18,26, ce_pix_n=1 at edges 14,22.
- `locked` high for 3 synchronised cycles, low for 1, then high -> stays out of RUN, re-enters FILTER, loss_count=0; release occurs 4+3 cycles after the second FILTER entry.
- In RUN, drop `locked` for one cycle -> sys_reset=1 and ce_pix=ce_pix_n=0 within 3 edges, loss_count=1, full re-acquire sequence before next release.
- Drop `locked` during HOLD -> back to WAIT_LOCK, loss_count increments by 1, sys_reset never deasserts.
- Force 300 loss events -> loss_count saturates at 255, no wrap.
- Assert rst asynchronously mid-RUN (between edges) -> sys_reset=1, enables 0, loss_count=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor for the 56 MHz core clock domain.
// Synchronises and filters the PLL lock flag, holds the core in reset for a
// fixed interval after lock is trusted, then releases it together with
// phase-aligned pixel clock enables. Any loss of lock drops straight back to
// reset and is counted in a saturating event counter.
module pll_lock_supervisor #(
  parameter int LOCK_FILTER = 1024,
  parameter int RESET_HOLD  = 256,
  parameter int CE_DIV      = 8,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       sys_reset,
  output logic       ready,
  output logic       ce_pix,
  output logic       ce_pix_n,
  output logic [7:0] loss_count
);

  localparam int DIV_W = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;

  localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF    = DIV_W'(CE_DIV / 2);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    FILTER,
    HOLD,
    RUN
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [DIV_W-1:0] div_cnt, div_next;
  logic [7:0]       loss_next;
  logic             loss_event;
  logic             sync1, locked_s;
  logic             sys_reset_next, ce_pix_next, ce_pix_n_next;

  // Two-flop synchroniser: locked comes from the PLL with no relation to clk.
  // NOTE: every clocked assignment is non-blocking so all flops sample the
  // pre-edge values; a blocking write here would collapse the chain into one flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= locked;
      locked_s <= sync1;
    end
  end

  // Next-state, counter, divider and output decode. Loss of lock is checked
  // before any terminal count so it always wins a same-cycle tie.
  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    div_next   = div_cnt;
    loss_event = 1'b0;

    unique case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_next = FILTER;
          cnt_next   = '0;
        end
      end
      FILTER: begin
        // A drop here is just an unstable lock, not a lost one: no count.
        if (!locked_s) begin
          state_next = WAIT_LOCK;
        end else if (cnt == FILTER_LAST) begin
          state_next = HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          loss_event = 1'b1;
        end else if (cnt == HOLD_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
          div_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          loss_event = 1'b1;
        end else begin
          div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
      end
      default: state_next = WAIT_LOCK;
    endcase

    loss_next = loss_count;
    if (loss_event && (loss_count != 8'hFF)) begin
      loss_next = loss_count + 8'd1;
    end

    // Outputs are decoded from the next state so they register on the same
    // edge as the state: the first ce_pix lands on the first released cycle.
    sys_reset_next = (state_next != RUN);
    ce_pix_next    = (state_next == RUN) && (div_next == '0);
    ce_pix_n_next  = (state_next == RUN) && (div_next == DIV_HALF);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      div_cnt    <= '0;
      loss_count <= 8'd0;
      sys_reset  <= 1'b1;
      ready      <= 1'b0;
      ce_pix     <= 1'b0;
      ce_pix_n   <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      div_cnt    <= div_next;
      loss_count <= loss_next;
      sys_reset  <= sys_reset_next;
      ready      <= ~sys_reset_next;
      ce_pix     <= ce_pix_next;
      ce_pix_n   <= ce_pix_n_next;
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor with short filter/hold intervals.
// Per-edge vectors are built from the release edge of each scenario; the
// expected record is queued when its stimulus is driven and compared after
// the edge that produces it.
module tb_pll_lock_supervisor;

  localparam int LOCK_FILTER = 4;
  localparam int RESET_HOLD  = 3;
  localparam int CE_DIV      = 8;
  localparam int CNT_W       = 16;
  localparam int NEVER       = 100000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       sys_reset, ready, ce_pix, ce_pix_n;
  logic [7:0] loss_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         edge_no;
    logic       locked;
    logic       sys_reset;
    logic       ready;
    logic       ce_pix;
    logic       ce_pix_n;
    logic [7:0] loss;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  pll_lock_supervisor #(
    .LOCK_FILTER(LOCK_FILTER),
    .RESET_HOLD (RESET_HOLD),
    .CE_DIV     (CE_DIV),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .locked    (locked),
    .sys_reset (sys_reset),
    .ready     (ready),
    .ce_pix    (ce_pix),
    .ce_pix_n  (ce_pix_n),
    .loss_count(loss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Edges are numbered from the first posedge after rst is released.
  // locked is low before drop_edge only; the core runs from run_from onward.
  task automatic fill(input int first_e, input int last_e, input int run_from,
                      input logic [7:0] loss, input int drop_edge);
    vec_t v;
    logic in_run;
    for (int e = first_e; e <= last_e; e++) begin
      in_run      = (e >= run_from);
      v.edge_no   = e;
      v.locked    = (e != drop_edge);
      v.sys_reset = !in_run;
      v.ready     = in_run;
      v.ce_pix    = in_run && (((e - run_from) % CE_DIV) == 0);
      v.ce_pix_n  = in_run && (((e - run_from) % CE_DIV) == CE_DIV / 2);
      v.loss      = loss;
      tbl.push_back(v);
    end
  endtask

  task automatic run_table(input string tag);
    vec_t v;
    vec_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      v      = tbl[i];
      locked = v.locked;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("%s e%0d sys_reset", tag, e.edge_no), 8'(sys_reset), 8'(e.sys_reset));
      check($sformatf("%s e%0d ready", tag, e.edge_no), 8'(ready), 8'(e.ready));
      check($sformatf("%s e%0d ce_pix", tag, e.edge_no), 8'(ce_pix), 8'(e.ce_pix));
      check($sformatf("%s e%0d ce_pix_n", tag, e.edge_no), 8'(ce_pix_n), 8'(e.ce_pix_n));
      check($sformatf("%s e%0d loss_count", tag, e.edge_no), loss_count, e.loss);
    end
    tbl.delete();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst    = 1'b1;
    locked = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_release;
    logic found;

    // Reset values while rst is held.
    repeat (2) @(posedge clk);
    #1;
    check("reset sys_reset", 8'(sys_reset), 8'd1);
    check("reset ready", 8'(ready), 8'd0);
    check("reset ce_pix", 8'(ce_pix), 8'd0);
    check("reset ce_pix_n", 8'(ce_pix_n), 8'd0);
    check("reset loss_count", loss_count, 8'd0);

    // Clean acquisition: release at edge 3+4+3.
    reset_dut();
    fill(1, 27, 10, 8'd0, 0);
    run_table("acquire");

    // Glitch during FILTER: second FILTER entry at edge 7, release at 14.
    reset_dut();
    fill(1, 16, 14, 8'd0, 4);
    run_table("glitch");

    // One-cycle drop in RUN: reset back at edge 15, refilter from 16, release at 23.
    reset_dut();
    fill(1, 14, 10, 8'd0, 13);
    fill(15, 25, 23, 8'd1, 13);
    run_table("runloss");

    // Asynchronous rst between edges while a ce_pix pulse is being driven.
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(posedge clk);
      #1;
      if (ce_pix) found = 1'b1;
    end
    check("async ce_pix seen before rst", 8'(found), 8'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async sys_reset", 8'(sys_reset), 8'd1);
    check("async ready", 8'(ready), 8'd0);
    check("async ce_pix", 8'(ce_pix), 8'd0);
    check("async ce_pix_n", 8'(ce_pix_n), 8'd0);
    check("async loss_count", loss_count, 8'd0);

    // Drop during HOLD: back to WAIT_LOCK at edge 8, release only at 16.
    reset_dut();
    fill(1, 7, NEVER, 8'd0, 6);
    fill(8, 18, 16, 8'd1, 6);
    run_table("holdloss");

    // 300 losses; each drop lands as the hold counter hits terminal, so loss
    // must win and the core must never be released.
    reset_dut();
    saw_release = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      locked = 1'b1;
      repeat (7) begin
        @(posedge clk);
        #1;
        if (!sys_reset) saw_release = 1'b1;
      end
      locked = 1'b0;
      repeat (3) begin
        @(posedge clk);
        #1;
        if (!sys_reset) saw_release = 1'b1;
      end
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300)
        check($sformatf("saturate loss_count after %0d", i), loss_count,
              (i > 255) ? 8'd255 : 8'(i));
    end
    check("saturate never released", 8'(saw_release), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
